// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake and PS/2 pin signals of the host transmitter.
//   tx_data/tx_valid/tx_ready : byte handshake (accept on tx_valid && tx_ready)
//   ps2_clk_in/ps2_data_in    : raw pin values seen by the transmitter
//   ps2_clk_oe/ps2_data_oe    : open-drain pull-low enables
//   busy/done/ack_err/timeout : transfer status
// master = top level / CPU side, slave = ps2_host_tx.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       timeout;

    modport master (
        output tx_data, tx_valid, ps2_clk_in, ps2_data_in,
        input  tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, ack_err, timeout
    );

    modport slave (
        input  tx_data, tx_valid, ps2_clk_in, ps2_data_in,
        output tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, ack_err, timeout
    );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Inhibits the bus, issues a request-to-send, shifts out 8 data bits LSB first
// plus odd parity on the device's falling clock edges, releases data for the
// stop bit and samples the device ACK. Pins are only ever pulled low.
//   CLK100MHZ : system clock
//   RESETN    : asynchronous reset, active low (releases both lines at once)
//   bus       : ps2_host_tx_if slave modport (handshake, pins, status)
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 12_000,
    parameter int unsigned START_TIMEOUT  = 1_500_000,
    parameter int unsigned XFER_TIMEOUT   = 200_000,
    parameter int unsigned FILTER_LEN     = 8
) (
    input  logic          CLK100MHZ,
    input  logic          RESETN,
    ps2_host_tx_if.slave  bus
);
    localparam int unsigned MAX_AB = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES : START_TIMEOUT;
    localparam int unsigned MAXP   = (MAX_AB > XFER_TIMEOUT) ? MAX_AB : XFER_TIMEOUT;
    localparam int unsigned CW     = $clog2(MAXP) + 1;
    localparam int unsigned FW     = $clog2(FILTER_LEN) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_START, S_BITS, S_ACK, S_WAIT_IDLE, S_DONE, S_FAIL
    } state_t;

    // ---------------- input conditioning (index 0 = clk, 1 = data) ----------------
    logic [1:0]         sync1_q, sync2_q, filt_q, filt_d;
    logic [1:0][FW-1:0] stab_q, stab_d;
    logic               clk_prev_q;
    logic               fall;

    // The filtered value only follows the synchronized input after it has
    // disagreed for FILTER_LEN consecutive cycles; any agreement restarts the count.
    always_comb begin
        filt_d = filt_q;
        stab_d = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            if (sync2_q[i] != filt_q[i]) begin
                if (stab_q[i] == FW'(FILTER_LEN - 1))
                    filt_d[i] = sync2_q[i];
                else
                    stab_d[i] = stab_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK100MHZ or negedge RESETN) begin
        if (!RESETN) begin
            sync1_q    <= '1;
            sync2_q    <= '1;
            filt_q     <= '1;
            stab_q     <= '0;
            clk_prev_q <= 1'b1;
        end else begin
            sync1_q    <= {bus.ps2_data_in, bus.ps2_clk_in};
            sync2_q    <= sync1_q;
            filt_q     <= filt_d;
            stab_q     <= stab_d;
            clk_prev_q <= filt_q[0];
        end
    end

    assign fall = clk_prev_q & ~filt_q[0];

    // ---------------- transfer FSM ----------------
    state_t        state_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [8:0]    shift_q;          // {parity, d7..d0}, shifted out LSB first
    logic [3:0]    idx_q;            // falling edges seen so far
    logic          clk_oe_q, data_oe_q, busy_q, done_q, ack_err_q, timeout_q, ready_q;

    // Shared saturating counter: inhibit time, start timeout, transfer timeout.
    assign cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge CLK100MHZ or negedge RESETN) begin
        if (!RESETN) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            idx_q     <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            timeout_q <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            done_q <= 1'b0;
            cnt_q  <= cnt_d;
            case (state_q)
                S_IDLE: begin
                    if (bus.tx_valid) begin
                        shift_q   <= {~^bus.tx_data, bus.tx_data};
                        ack_err_q <= 1'b0;
                        timeout_q <= 1'b0;
                        ready_q   <= 1'b0;
                        busy_q    <= 1'b1;
                        clk_oe_q  <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
                        clk_oe_q  <= 1'b0;
                        data_oe_q <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= S_START;
                    end
                end
                S_START: begin
                    // Timeout is tested first so it wins over a same-cycle fall.
                    if (cnt_q == CW'(START_TIMEOUT - 1)) begin
                        timeout_q <= 1'b1;
                        ack_err_q <= 1'b0;
                        clk_oe_q  <= 1'b0;
                        data_oe_q <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= S_FAIL;
                    end else if (fall) begin
                        data_oe_q <= ~shift_q[0];
                        shift_q   <= shift_q >> 1;
                        idx_q     <= 4'd1;
                        cnt_q     <= '0;
                        state_q   <= S_BITS;
                    end
                end
                S_BITS, S_ACK, S_WAIT_IDLE: begin
                    if (cnt_q == CW'(XFER_TIMEOUT - 1)) begin
                        timeout_q <= 1'b1;
                        ack_err_q <= 1'b0;
                        clk_oe_q  <= 1'b0;
                        data_oe_q <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= S_FAIL;
                    end else if (state_q == S_WAIT_IDLE) begin
                        if (filt_q == 2'b11) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end else if (fall) begin
                        if (state_q == S_ACK) begin
                            ack_err_q <= filt_q[1];
                            state_q   <= S_WAIT_IDLE;
                        end else if (idx_q == 4'd9) begin
                            data_oe_q <= 1'b0;     // stop bit: line released
                            state_q   <= S_ACK;
                        end else begin
                            data_oe_q <= ~shift_q[0];
                            shift_q   <= shift_q >> 1;
                            idx_q     <= idx_q + 1'b1;
                        end
                    end
                end
                S_DONE, S_FAIL: begin
                    data_oe_q <= 1'b0;
                    busy_q    <= 1'b0;
                    ready_q   <= 1'b1;
                    state_q   <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.tx_ready    = ready_q;
    assign bus.ps2_clk_oe  = clk_oe_q;
    assign bus.ps2_data_oe = data_oe_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.ack_err     = ack_err_q;
    assign bus.timeout     = timeout_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: self-checking bench for ps2_host_tx with a behavioural
// PS/2 device (clock generator, rising-edge data sampler, optional ACK).
module tb_ps2_host_tx;
    localparam int unsigned INH   = 120;
    localparam int unsigned ST_TO = 600;
    localparam int unsigned XF_TO = 1500;
    localparam int unsigned FL    = 8;
    localparam int          HALF  = 40;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ps2_host_tx_if bus();

    logic dev_clk_low = 1'b0;
    logic dev_data_low = 1'b0;
    assign bus.ps2_clk_in  = ~(bus.ps2_clk_oe | dev_clk_low);
    assign bus.ps2_data_in = ~(bus.ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .START_TIMEOUT (ST_TO),
        .XFER_TIMEOUT  (XF_TO),
        .FILTER_LEN    (FL)
    ) dut (
        .CLK100MHZ(clk),
        .RESETN   (rst_n),
        .bus      (bus)
    );

    int n_asserts = 0;
    int n_fail    = 0;

    // ---------------- passive monitor ----------------
    int   cyc = 0;
    int   done_cnt = 0, done_cyc = 0, start_cyc = -1, bits_cyc = -1, inh_rise = 0, inh_len = -1;
    logic done_ack = 1'b0, done_to = 1'b0, done_oe = 1'b0, ready_after = 1'b0;
    logic prev_clk_oe = 1'b0, prev_data_oe = 1'b0, pend = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pend) begin
            ready_after = bus.tx_ready;
            pend = 1'b0;
        end
        if (bus.ps2_clk_oe && !prev_clk_oe) inh_rise = cyc;
        if (!bus.ps2_clk_oe && prev_clk_oe) begin
            inh_len = cyc - inh_rise;
            if (bus.ps2_data_oe) begin
                start_cyc = cyc;
                bits_cyc  = -1;
            end
        end
        if (!bus.ps2_data_oe && prev_data_oe && !bus.ps2_clk_oe && bits_cyc < 0) bits_cyc = cyc;
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
            done_ack = bus.ack_err;
            done_to  = bus.timeout;
            done_oe  = bus.ps2_clk_oe | bus.ps2_data_oe;
            pend     = 1'b1;
        end
        prev_clk_oe  = bus.ps2_clk_oe;
        prev_data_oe = bus.ps2_data_oe;
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference frame as the device sees it: start, d0..d7, odd parity, stop.
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = b[i];
        f[9]  = ($countones(b) % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic send(input logic [7:0] b);
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        tick();
        bus.tx_valid = 1'b0;
    endtask

    task automatic wait_done(input int n0, input int budget, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            if (done_cnt > n0) seen = 1'b1;
            else tick();
        end
        if (done_cnt > n0) seen = 1'b1;
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        tick();
    endtask

    // Device: waits for request-to-send, samples the start bit, then generates
    // nclk clock pulses sampling data on each rising edge.
    task automatic dev_frame(input int nclk, input bit ack, input int glitch_at,
                             output logic [10:0] got);
        bit ok = 1'b0;
        got = '0;
        for (int i = 0; i < int'(INH) + 100 && !ok; i++) begin
            if (!bus.ps2_clk_oe && bus.ps2_data_oe) ok = 1'b1;
            else tick();
        end
        check("start_seen", 32'(ok), 32'd1);
        repeat (20) tick();
        got[0] = bus.ps2_data_in;
        for (int e = 1; e <= nclk; e++) begin
            if (e == 11 && ack) begin
                dev_data_low = 1'b1;
                repeat (5) tick();
            end
            dev_clk_low = 1'b1;
            repeat (HALF) tick();
            dev_clk_low = 1'b0;
            if (e <= 10) got[e] = bus.ps2_data_in;
            if (e == 11) dev_data_low = 1'b0;
            if (e == glitch_at) begin
                repeat (15) tick();
                dev_clk_low = 1'b1;
                repeat (5) tick();
                dev_clk_low = 1'b0;
                repeat (HALF - 20) tick();
            end else begin
                repeat (HALF) tick();
            end
        end
    endtask

    task automatic run_frame(input logic [7:0] b, input bit ack, input int glitch_at, input string tag);
        int n0;
        logic [10:0] got;
        n0 = done_cnt;
        send(b);
        check({tag, "_status_cleared"}, {30'd0, bus.ack_err, bus.timeout}, 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        dev_frame(11, ack, glitch_at, got);
        check({tag, "_frame"}, 32'(got), 32'(frame_of(b)));
        wait_done(n0, 400, tag);
        check({tag, "_inhibit_len"}, 32'(inh_len), INH);
        check({tag, "_ack_err"}, 32'(done_ack), 32'(!ack));
        check({tag, "_timeout"}, 32'(done_to), 32'd0);
        check({tag, "_oe_at_done"}, 32'(done_oe), 32'd0);
        check({tag, "_ready_after"}, 32'(ready_after), 32'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [7:0]  b, b2;
        logic [10:0] got;
        int          n0;

        bus.tx_data  = '0;
        bus.tx_valid = 1'b0;
        repeat (3) tick();
        check("reset_outputs",
              {25'd0, bus.tx_ready, bus.busy, bus.done, bus.ps2_clk_oe, bus.ps2_data_oe, bus.ack_err, bus.timeout},
              32'b1000000);
        rst_n = 1'b1;
        repeat (20) tick();

        run_frame(8'hED, 1'b1, 0, "ed");
        run_frame(8'hF4, 1'b1, 0, "f4");

        run_frame($urandom, 1'b0, 0, "noack");
        repeat (10) tick();
        check("ack_err_hold", 32'(bus.ack_err), 32'd1);

        run_frame($urandom, 1'b1, 4, "glitch");

        // Device never clocks.
        n0 = done_cnt;
        send($urandom);
        dev_frame(0, 1'b0, 0, got);
        wait_done(n0, ST_TO + 100, "start_to");
        check("start_to_latency", 32'(done_cyc - start_cyc), ST_TO);
        check("start_to_flags", {30'd0, done_to, done_ack}, 32'b10);
        check("start_to_oe", 32'(done_oe), 32'd0);
        repeat (10) tick();
        check("timeout_hold", 32'(bus.timeout), 32'd1);

        // Device stops after 5 clocks; d0 = 1 makes BITS entry visible on data_oe.
        n0 = done_cnt;
        b = 8'($urandom) | 8'h01;
        send(b);
        dev_frame(5, 1'b0, 0, got);
        check("xfer_partial_frame", 32'(got[5:0]), 32'(frame_of(b) & 11'h03F));
        wait_done(n0, XF_TO + 200, "xfer_to");
        check("xfer_to_latency", 32'(done_cyc - bits_cyc), XF_TO);
        check("xfer_to_flags", {30'd0, done_to, done_ack}, 32'b10);
        check("xfer_to_oe", 32'(done_oe), 32'd0);

        for (int k = 0; k < 3; k++) run_frame($urandom, 1'b1, 0, $sformatf("rand%0d", k));

        // Reset while in BITS with data pulled low (all-zero byte).
        send(8'h00);
        dev_frame(3, 1'b0, 0, got);
        check("pre_reset_data_oe", 32'(bus.ps2_data_oe), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("reset_mid_oe", {30'd0, bus.ps2_clk_oe, bus.ps2_data_oe}, 32'd0);
        check("reset_mid_status", {30'd0, bus.busy, bus.tx_ready}, 32'b01);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (20) tick();
        check("ready_after_reset", 32'(bus.tx_ready), 32'd1);

        // Back-to-back with tx_valid held high.
        n0 = done_cnt;
        b  = $urandom;
        b2 = $urandom;
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        tick();
        bus.tx_data = b2;
        dev_frame(11, 1'b1, 0, got);
        check("b2b_first_frame", 32'(got), 32'(frame_of(b)));
        wait_done(n0, 400, "b2b_first");
        check("b2b_accept_cycle", 32'(inh_rise), 32'(done_cyc + 2));
        bus.tx_valid = 1'b0;
        n0 = done_cnt;
        dev_frame(11, 1'b1, 0, got);
        check("b2b_second_frame", 32'(got), 32'(frame_of(b2)));
        wait_done(n0, 400, "b2b_second");
        check("b2b_second_flags", {30'd0, done_to, done_ack}, 32'd0);

        repeat (10) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
